// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC, zero word and
// the fetch-queue entry layout {pc, inst}.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W   = 32;
  localparam int unsigned CPU_DATA_W   = 32;
  localparam int unsigned CPU_FQ_DEPTH = 4;

  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [CPU_DATA_W-1:0] ZERO_WORD    = 32'h0000_0000;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] inst;
  } fq_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// Synchronous power-of-two FIFO holding fetched {pc, inst} entries.
// A flush empties it, or keeps only the head entry when keep_head_i is set.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     keep_head_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests so a misbehaving caller cannot overrun or underrun.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (flush_i) begin
      do_pop_s  = 1'b0;
      do_push_s = 1'b0;
    end else begin
      do_pop_s  = pop_i && (count_q != {CW{1'b0}});
      do_push_s = push_i && ((count_q != DEPTH_C) || do_pop_s);
    end
  end

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      if (keep_head_i && (count_q != {CW{1'b0}})) begin
        wr_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = CNT_ONE;
      end else begin
        wr_ptr_d = rd_ptr_q;
        count_d  = {CW{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : fetch_queue

// File: rtl/inst_fetch.sv
// Instruction fetch stage: zero-latency ROM fetch into a small queue feeding decode.
// Define DELAY_SLOT_EN to keep the queue head (delay slot) across a redirect.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = CPU_ADDR_W,
  parameter int                 DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(CPU_RESET_PC),
  parameter int                 FQ_DEPTH = CPU_FQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        rom_ce,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_inst,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [ADDR_W-1:0]           id_pc,
  output logic [DATA_W-1:0]           id_inst,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C    = CW'(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};

`ifdef DELAY_SLOT_EN
  localparam logic KEEP_HEAD = 1'b1;
`else
  localparam logic KEEP_HEAD = 1'b0;
`endif

  if ((FQ_DEPTH < 2) || ((FQ_DEPTH & (FQ_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("inst_fetch: FQ_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [CW-1:0]            count_s;
  logic [ADDR_W+DATA_W-1:0] head_s;
  logic                     valid_s;
  logic                     pop_s;
  logic                     fetch_s;
  logic                     flush_s;

  // Handshake: decode sees the head unless reset or a redirect is squashing it.
  always_comb begin
    valid_s = 1'b0;
    pop_s   = 1'b0;
    fetch_s = 1'b0;
    flush_s = 1'b0;
    if (rst) begin
      valid_s = 1'b0;
      pop_s   = 1'b0;
      fetch_s = 1'b0;
      flush_s = 1'b0;
    end else if (redirect_valid) begin
      valid_s = 1'b0;
      pop_s   = 1'b0;
      fetch_s = 1'b0;
      flush_s = 1'b1;
    end else begin
      valid_s = (count_s != {CW{1'b0}});
      pop_s   = valid_s && id_ready;
      fetch_s = (count_s < DEPTH_C) || pop_s;
      flush_s = 1'b0;
    end
  end

  // PC next-state: redirect target is forced word-aligned; increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (fetch_s) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register; reset wins over any concurrent redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch_s),
    .pop_i       (pop_s),
    .flush_i     (flush_s),
    .keep_head_i (KEEP_HEAD),
    .din_i       ({pc_q, rom_inst}),
    .dout_o      (head_s),
    .count_o     (count_s)
  );

  assign rom_ce   = fetch_s;
  assign rom_addr = pc_q & ALIGN_MASK;
  assign id_valid = valid_s;
  assign id_pc    = head_s[ADDR_W+DATA_W-1:DATA_W];
  assign id_inst  = head_s[DATA_W-1:0];
  assign fq_count = count_s;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed phases push expected decode entries,
// a negedge monitor pops and compares each accepted delivery.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  fq_count;

  int n_checks = 0;
  int n_pass   = 0;
  fq_entry_t exp_q[$];

`ifdef DELAY_SLOT_EN
  localparam logic [31:0] DS_KEEP = 32'd1;
`else
  localparam logic [31:0] DS_KEEP = 32'd0;
`endif

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .fq_count       (fq_count)
  );

  // ROM model: word n holds value n.
  assign rom_inst = {2'b00, rom_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] p);
    fq_entry_t e;
    e.pc   = p;
    e.inst = {2'b00, p[31:2]};
    exp_q.push_back(e);
  endtask

  // Monitor: compares every accepted head and checks stability under stall.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    fq_entry_t   e;
    prev_stall = 1'b0;
    prev_pc    = 32'h0;
    prev_inst  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && id_valid) begin
        if (prev_stall) begin
          check("stall_pc_stable", id_pc, prev_pc);
          check("stall_inst_stable", id_inst, prev_inst);
        end
        if (id_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got pc %h expected no delivery", id_pc);
          end else begin
            e = exp_q.pop_front();
            check("deliver_pc", id_pc, e.pc);
            check("deliver_inst", id_inst, e.inst);
          end
        end
      end
      prev_stall = !rst && id_valid && !id_ready;
      prev_pc    = id_pc;
      prev_inst  = id_inst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ce_cnt;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_rom_ce", rom_ce, 32'd0);
    check("rst_id_valid", id_valid, 32'd0);
    check("rst_fq_count", fq_count, 32'd0);
    check("rst_rom_addr", rom_addr, 32'h0);

    // Streaming after reset release: one delivery per cycle after the first.
    tick();
    rst      = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k < 7; k++) expect_pc(32'(4 * k));
    @(negedge clk);
    check("stream_c0_ce", rom_ce, 32'd1);
    check("stream_c0_addr", rom_addr, 32'h0);
    check("stream_c0_valid", id_valid, 32'd0);
    repeat (7) tick();

    // Backpressure: exactly FQ_DEPTH fetches then hold.
    tick();
    rst      = 1'b1;
    id_ready = 1'b0;
    tick();
    rst    = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rom_ce) ce_cnt++;
      tick();
    end
    check("stall_fetch_count", ce_cnt, 32'd4);
    @(negedge clk);
    check("stall_fq_count", fq_count, 32'd4);
    check("stall_rom_addr", rom_addr, 32'h10);
    check("stall_rom_ce", rom_ce, 32'd0);
    check("stall_head_pc", id_pc, 32'h0);
    tick();
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_pc(32'(4 * k));
    @(negedge clk);
    check("full_pop_ce", rom_ce, 32'd1);
    repeat (5) tick();

    // Redirect with three entries queued.
    tick();
    rst      = 1'b1;
    id_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    id_ready       = 1'b1;
    @(negedge clk);
    check("redir_fq_count_before", fq_count, 32'd3);
    check("redir_id_valid", id_valid, 32'd0);
    check("redir_rom_ce", rom_ce, 32'd0);
    tick();
    redirect_valid = 1'b0;
    if (DS_KEEP == 32'd1) expect_pc(32'h0);
    expect_pc(32'h100);
    expect_pc(32'h104);
    expect_pc(32'h108);
    @(negedge clk);
    check("redir_rom_addr", rom_addr, 32'h100);
    check("redir_fq_count_after", fq_count, DS_KEEP);
    check("redir_valid_after", id_valid, DS_KEEP);
    repeat (3) tick();

    // Back-to-back redirects, last one wins, then PC wrap.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    check("b2b_id_valid", id_valid, 32'd0);
    tick();
    redirect_valid = 1'b0;
    if (DS_KEEP == 32'd1) expect_pc(32'h10C);
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    @(negedge clk);
    check("b2b_rom_addr", rom_addr, 32'hFFFF_FFF8);
    repeat (3) tick();

    // Reset over a full queue and a concurrent redirect.
    tick();
    id_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("full_fq_count", fq_count, 32'd4);
    check("full_rom_ce", rom_ce, 32'd0);
    tick();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    check("rst_mid_rom_ce", rom_ce, 32'd0);
    check("rst_mid_id_valid", id_valid, 32'd0);
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    @(negedge clk);
    check("rst_rel_fq_count", fq_count, 32'd0);
    check("rst_rel_id_valid", id_valid, 32'd0);
    check("rst_rel_rom_addr", rom_addr, 32'h0);
    check("rst_rel_rom_ce", rom_ce, 32'd1);
    tick();
    tick();
    tick();
    id_ready = 1'b0;
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_inst_fetch
